// File: rtl/approx_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : approx_mult_pkg
//  Description : Shared constants for the approximate multiplier pipeline:
//                mode encoding, stage count and the column-sum width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package approx_mult_pkg;

    localparam logic MODE_EXACT         = 1'b0;
    localparam logic MODE_APPROX        = 1'b1;
    localparam int   APPROX_MULT_STAGES = 2;

    // Bits needed to hold the population count of a WIDTH-bit column.
    function automatic int col_sum_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : approx_mult_pkg
`default_nettype wire

// File: rtl/approx_mult_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : approx_mult_pipe_if
//  Description : Operand/result handshake bundle of approx_mult_pipe.
//                master : producer/consumer side (drives operands, out_ready)
//                slave  : multiplier side (drives in_ready and results)
//                With APPROX_MULT_ERR_STAT_EN defined the bundle also carries
//                err_o and approx_cnt_o.
//  Revision    : 1.0 - initial release
// ============================================================================
interface approx_mult_pipe_if #(
    parameter int WIDTH = 8
);
    import approx_mult_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a_i;
    logic [WIDTH-1:0]       b_i;
    logic                   mode_i;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     p_o;
    logic                   mode_o;

`ifdef APPROX_MULT_ERR_STAT_EN
    logic [2*WIDTH-1:0]     err_o;
    logic [31:0]            approx_cnt_o;

    modport master (
        output in_valid, a_i, b_i, mode_i, out_ready,
        input  in_ready, out_valid, p_o, mode_o, err_o, approx_cnt_o
    );
    modport slave (
        input  in_valid, a_i, b_i, mode_i, out_ready,
        output in_ready, out_valid, p_o, mode_o, err_o, approx_cnt_o
    );
`else
    modport master (
        output in_valid, a_i, b_i, mode_i, out_ready,
        input  in_ready, out_valid, p_o, mode_o
    );
    modport slave (
        input  in_valid, a_i, b_i, mode_i, out_ready,
        output in_ready, out_valid, p_o, mode_o
    );
`endif

endinterface : approx_mult_pipe_if
`default_nettype wire

// File: rtl/approx_col_reduce.sv
`default_nettype none
// ============================================================================
//  Module      : approx_col_reduce
//  Description : Reduces one product column. Exact mode returns the number
//                of set partial-product bits; approximate mode returns their
//                OR, so the column can never produce a carry.
//  Ports       : col_bits (in, WIDTH) partial products of the column
//                mode     (in, 1)     MODE_EXACT / MODE_APPROX
//                col_sum  (out, CW)   count or OR, zero-extended
//  Revision    : 1.0 - initial release
// ============================================================================
module approx_col_reduce
    import approx_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = col_sum_width(WIDTH)
) (
    input  logic [WIDTH-1:0] col_bits,
    input  logic             mode,
    output logic [CW-1:0]    col_sum
);

    logic [CW-1:0] pop_cnt;

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_cnt = pop_cnt + CW'(col_bits[i]);
        end
    end

    assign col_sum = (mode == MODE_APPROX) ? CW'(|col_bits) : pop_cnt;

endmodule : approx_col_reduce
`default_nettype wire

// File: rtl/approx_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : approx_mult_pipe
//  Description : Two-stage unsigned WIDTH x WIDTH multiplier with a per-beat
//                exact/approximate mode. The lowest APPROX_COLS product
//                columns are OR-reduced in approximate mode; all higher
//                columns are always summed exactly.
//                Stage 1 registers the per-column reductions, stage 2
//                registers the weighted sum. Valid/ready on both sides.
//  Ports       : clk, rst (async, active high)
//                bus (approx_mult_pipe_if.slave): in_valid/in_ready, a_i,
//                b_i, mode_i, out_valid/out_ready, p_o, mode_o
//  Config      : APPROX_MULT_ERR_STAT_EN adds err_o (exact - p_o) and
//                approx_cnt_o (saturating count of approximate results).
//  Revision    : 1.0 - initial release
// ============================================================================
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 4
) (
    input  logic               clk,
    input  logic               rst,
    approx_mult_pipe_if.slave  bus
);

    localparam int PW   = 2 * WIDTH;
    localparam int NCOL = PW - 1;
    localparam int CW   = col_sum_width(WIDTH);

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic s2_adv;
    logic in_ready_int;

    assign s2_adv       = !s2_valid || bus.out_ready;
    // Stage 1 advances exactly when stage 2 can take its content.
    assign in_ready_int = !s1_valid || s2_adv;

    // ------------------------------------------------------------------
    // Column formation and reduction
    // ------------------------------------------------------------------
    logic [NCOL-1:0][WIDTH-1:0] col_bits;
    logic [NCOL-1:0][CW-1:0]    col_red;

    generate
        for (genvar k = 0; k < NCOL; k++) begin : g_col
            logic col_mode;

            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                if ((k - i) >= 0 && (k - i) < WIDTH) begin : g_pp
                    assign col_bits[k][i] = bus.a_i[i] & bus.b_i[k-i];
                end else begin : g_zero
                    assign col_bits[k][i] = 1'b0;
                end
            end

            // Only the low columns ever see the beat's approximate mode.
            if (k < APPROX_COLS) begin : g_apx
                assign col_mode = bus.mode_i;
            end else begin : g_exa
                assign col_mode = MODE_EXACT;
            end

            approx_col_reduce #(
                .WIDTH (WIDTH),
                .CW    (CW)
            ) u_col_reduce (
                .col_bits (col_bits[k]),
                .mode     (col_mode),
                .col_sum  (col_red[k])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 1: column reductions
    // ------------------------------------------------------------------
    logic [NCOL-1:0][CW-1:0] s1_cols;
    logic                    s1_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_cols  <= '0;
            s1_mode  <= MODE_EXACT;
        end else if (in_ready_int) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_cols <= col_red;
                s1_mode <= bus.mode_i;
            end
        end
    end

    // Weighted column sum. Approximate columns hold 0/1 at distinct weights
    // below all exact columns, so no carry can reach or leave them.
    logic [PW-1:0] col_total;

    always_comb begin
        col_total = '0;
        for (int k = 0; k < NCOL; k++) begin
            col_total = col_total + (PW'(s1_cols[k]) << k);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: final product
    // ------------------------------------------------------------------
    logic [PW-1:0] p_reg;
    logic          mode_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            p_reg    <= '0;
            mode_reg <= MODE_EXACT;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                p_reg    <= col_total;
                mode_reg <= s1_mode;
            end
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = s2_valid;
    assign bus.p_o       = p_reg;
    assign bus.mode_o    = mode_reg;

`ifdef APPROX_MULT_ERR_STAT_EN
    // ------------------------------------------------------------------
    // Shadow exact product and error statistics
    // ------------------------------------------------------------------
    logic [PW-1:0] s1_exact;
    logic [PW-1:0] err_reg;
    logic [31:0]   approx_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_exact <= '0;
        end else if (in_ready_int && bus.in_valid) begin
            s1_exact <= PW'(bus.a_i) * PW'(bus.b_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= '0;
        end else if (s2_adv && s1_valid) begin
            err_reg <= s1_exact - col_total;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            approx_cnt <= '0;
        end else if (s2_valid && bus.out_ready && (mode_reg == MODE_APPROX)
                     && (approx_cnt != '1)) begin
            approx_cnt <= approx_cnt + 32'd1;
        end
    end

    assign bus.err_o        = err_reg;
    assign bus.approx_cnt_o = approx_cnt;
`endif

endmodule : approx_mult_pipe
`default_nettype wire

// File: doc/approx_mult_pipe.md
APPROX_MULT_PIPE -- requirements
Module: approx_mult_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width, legal range 4..16.
REQ-002 SHALL have parameter APPROX_COLS, default 4: number of low product columns reduced approximately, legal range 0..2*WIDTH-1.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operand beat valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts a beat.
REQ-007 SHALL have ports a_i and b_i, input, WIDTH each: unsigned operands.
REQ-008 SHALL have port mode_i, input, 1: 1 = approximate, 0 = exact; travels with its beat.
REQ-009 SHALL have port out_valid, output, 1: result valid.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port p_o, output, 2*WIDTH: product.
REQ-012 SHALL have port mode_o, output, 1: mode of the beat on p_o.

Function
REQ-013 SHALL accept a beat when in_valid and in_ready are both high at a rising edge; SHALL present a result when out_valid and out_ready are both high.
REQ-014 In exact mode, SHALL produce p_o = a_i*b_i, mod nothing (full 2*WIDTH bits).
REQ-015 In approximate mode, SHALL produce p_o = sum over k<APPROX_COLS of OR(column-k partial products)*2^k, plus the exact sum of all partial products a[i]&b[j] with i+j >= APPROX_COLS. No carry leaves the approximate columns.
REQ-016 SHALL be a 2-stage pipeline: stage 1 registers column-reduced partials; stage 2 registers final sum; latency = 2 cycles from acceptance to out_valid with no stall.
REQ-017 SHALL sustain 1 beat/cycle when out_ready is held high.
REQ-018 Each stage SHALL advance when it is empty or its downstream stage advances in the same cycle; in_ready = !s1_valid | s1_advance (combinational, no dependency on in_valid).
REQ-019 While out_valid=1 and out_ready=0, p_o and mode_o SHALL hold stable and no beat SHALL be lost or duplicated.
REQ-020 Full pipeline (both stages valid) with out_ready=0 SHALL drive in_ready=0; a simultaneous output drain and input accept SHALL both occur in that cycle.
REQ-021 APPROX_COLS=0 SHALL make both modes exact.

Reset
REQ-022 rst high SHALL immediately clear all stage valid flags; out_valid=0, p_o=0, mode_o=0.
REQ-023 Beats in flight at reset SHALL be discarded, never emitted; in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-024 Macro APPROX_MULT_ERR_STAT_EN defined: SHALL add output err_o (2*WIDTH) = exact product minus p_o, aligned with p_o (0 in exact mode), and output approx_cnt_o (32), counting approximate-mode results handed off, saturating at all-ones, reset to 0.
REQ-025 Macro undefined: err_o and approx_cnt_o and the shadow exact path SHALL not exist.

Structure
REQ-026 Package approx_mult_pkg SHALL hold the mode encoding constants (MODE_EXACT=0, MODE_APPROX=1) and the stage-count constant APPROX_MULT_STAGES=2.
REQ-027 Per-column reduction SHALL live in sub-module approx_col_reduce (input: column bit vector, mode; output: column count or OR), one instance per product column.

Verification
REQ-028 WIDTH=8, APPROX_COLS=4: a=0x0F, b=0x0F, mode=0 -> p_o=0x00E1 after 2 cycles; mode=1 -> p_o=0x00BF (err_o=0x0022 if enabled).
REQ-029 a=0x03, b=0x03, mode=1 -> p_o=0x0007; mode=0 -> 0x0009; a=0xFF, b=0x01 -> 0x00FF in both modes.
REQ-030 Back-to-back 16 random beats with out_ready=1 -> 16 results in order, one per cycle, matching the REQ-014/015 golden model.
REQ-031 out_ready held low 5 cycles with in_valid high -> in_ready falls after 2 accepts, p_o stable, then all beats drain in order.
REQ-032 Assert rst with 2 beats in flight -> out_valid=0 at once, no result emitted after release, approx_cnt_o=0.
REQ-033 APPROX_COLS=0, mode=1, a=0xFF, b=0xFF -> p_o=0xFE01.
